// File: rtl/digit_entry_pkg.sv
// Shared constants and helpers for the digit entry block.
// FSM encoding, display mode codes, per-digit limits, BCD conversion helpers.
package digit_entry_pkg;

  // Digit states are consecutive, so "advance" is a plain increment.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_D3     = 3'd1;
  localparam logic [2:0] S_D2     = 3'd2;
  localparam logic [2:0] S_D1     = 3'd3;
  localparam logic [2:0] S_D0     = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  localparam logic [1:0] MODE_HHMM     = 2'd0;
  localparam logic [1:0] MODE_HHMM_ALT = 2'd1;
  localparam logic [1:0] MODE_MMSS     = 2'd2;
  localparam logic [1:0] MODE_OFF      = 2'd3;

  localparam logic [3:0] HR_TENS_MAX      = 4'd2;
  localparam logic [3:0] HR_ONES_MAX_AT_2 = 4'd3;
  localparam logic [3:0] MS_TENS_MAX      = 4'd5;
  localparam logic [3:0] ONES_MAX         = 4'd9;

  typedef struct packed {
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd4_t;

  // Split a 0..99 value into {tens, ones} BCD digits.
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
    bin_to_bcd2 = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Increment with wrap to 0 once the digit limit is reached.
  function automatic logic [3:0] bump_digit(input logic [3:0] d, input logic [3:0] max);
    bump_digit = (d >= max) ? 4'd0 : 4'(d + 4'd1);
  endfunction

  function automatic logic is_hhmm(input logic [1:0] m);
    is_hhmm = (m == MODE_HHMM) || (m == MODE_HHMM_ALT);
  endfunction

endpackage

// File: rtl/digit_entry_pair.sv
// bcd_pair_to_bin: combinational two-digit BCD to binary.
// Ports: tens, ones (4b BCD) in; value (7b binary, tens*10+ones) out.
module bcd_pair_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] value
);

  assign value = 7'(7'(tens) * 7'd10) + 7'(ones);

endmodule

// File: rtl/digit_entry.sv
// digit_entry: BCD digit editor that commits binary time values to the time counters.
// Ports: clk, reset_n (async active-low); state (display mode), edit_req, btn_next,
//   btn_inc (1-cycle pulses); cur_hours/minutes/seconds (current time);
//   thousands..ones (edit digits), digit_sel, busy, set_hours/minutes/seconds, load.
// Build option: DIGIT_ENTRY_TIMEOUT_EN enables the idle timeout (TIMEOUT_CYCLES).
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] state,
  input  logic       edit_req,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic [3:0] thousands,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] digit_sel,
  output logic       busy,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       load
);

  logic [2:0] fsm_q, fsm_d;
  logic [1:0] mode_q, mode_d;
  bcd4_t      dig_q, dig_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       load_q, load_d;
  logic [4:0] sh_q, sh_d;
  logic [5:0] sm_q, sm_d;
  logic [5:0] ss_q, ss_d;
  logic [6:0] hi_val, lo_val;
  logic [7:0] pre_hi, pre_lo;
  logic       mode_hh, req_hh, timeout, in_digit;

  bcd_pair_to_bin u_hi (.tens(dig_q.thousands), .ones(dig_q.hundreds), .value(hi_val));
  bcd_pair_to_bin u_lo (.tens(dig_q.tens),      .ones(dig_q.ones),     .value(lo_val));

  // Mode of the running session vs. mode requested by a new edit.
  assign mode_hh  = is_hhmm(mode_q);
  assign req_hh   = is_hhmm(state);
  assign pre_hi   = bin_to_bcd2(req_hh ? 7'(cur_hours)   : 7'(cur_minutes));
  assign pre_lo   = bin_to_bcd2(req_hh ? 7'(cur_minutes) : 7'(cur_seconds));
  assign in_digit = (fsm_q == S_D3) || (fsm_q == S_D2) || (fsm_q == S_D1) || (fsm_q == S_D0);

`ifdef DIGIT_ENTRY_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt_q;

  // Idle counter; held at zero outside digit states so D3 entry starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= '0;
    else if (!in_digit || btn_next || btn_inc) to_cnt_q <= '0;
    else to_cnt_q <= to_cnt_q + CNT_W'(1);
  end

  assign timeout = in_digit && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q  <= S_IDLE;
      mode_q <= MODE_HHMM;
      dig_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      load_q <= 1'b0;
      sh_q   <= '0;
      sm_q   <= '0;
      ss_q   <= '0;
    end else begin
      fsm_q  <= fsm_d;
      mode_q <= mode_d;
      dig_q  <= dig_d;
      sel_q  <= sel_d;
      busy_q <= busy_d;
      load_q <= load_d;
      sh_q   <= sh_d;
      sm_q   <= sm_d;
      ss_q   <= ss_d;
    end
  end

  // Next-state, digit edit and commit logic.
  always_comb begin
    fsm_d  = fsm_q;
    mode_d = mode_q;
    dig_d  = dig_q;
    load_d = 1'b0;
    sh_d   = sh_q;
    sm_d   = sm_q;
    ss_d   = ss_q;

    case (fsm_q)
      S_IDLE: begin
        if (edit_req && (state != MODE_OFF)) begin
          fsm_d  = S_D3;
          mode_d = state;
          dig_d  = {pre_hi, pre_lo};
        end
      end
      S_D3, S_D2, S_D1, S_D0: begin
        if ((state != mode_q) || timeout) begin
          fsm_d = S_IDLE;
        end else if (btn_next) begin
          fsm_d = 3'(fsm_q + 3'd1);  // D0 + 1 is COMMIT
          if ((fsm_q == S_D3) && mode_hh && (dig_q.thousands == HR_TENS_MAX) &&
              (dig_q.hundreds > HR_ONES_MAX_AT_2))
            dig_d.hundreds = HR_ONES_MAX_AT_2;
        end else if (btn_inc) begin
          case (fsm_q)
            S_D3: dig_d.thousands = bump_digit(dig_q.thousands,
                                               mode_hh ? HR_TENS_MAX : MS_TENS_MAX);
            S_D2: dig_d.hundreds  = bump_digit(dig_q.hundreds,
                      (mode_hh && (dig_q.thousands == HR_TENS_MAX)) ? HR_ONES_MAX_AT_2 : ONES_MAX);
            S_D1: dig_d.tens      = bump_digit(dig_q.tens, MS_TENS_MAX);
            S_D0: dig_d.ones      = bump_digit(dig_q.ones, ONES_MAX);
            default: ;
          endcase
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    // set_* are loaded on the same edge that raises load.
    if (fsm_d == S_COMMIT) begin
      load_d = 1'b1;
      if (mode_hh) begin
        sh_d = 5'(hi_val);
        sm_d = 6'(lo_val);
        ss_d = 6'd0;
      end else begin
        sh_d = cur_hours;
        sm_d = 6'(hi_val);
        ss_d = 6'(lo_val);
      end
    end

    busy_d = (fsm_d != S_IDLE);
    case (fsm_d)
      S_D3:    sel_d = 2'd3;
      S_D2:    sel_d = 2'd2;
      S_D1:    sel_d = 2'd1;
      default: sel_d = 2'd0;
    endcase
  end

  assign thousands   = dig_q.thousands;
  assign hundreds    = dig_q.hundreds;
  assign tens        = dig_q.tens;
  assign ones        = dig_q.ones;
  assign digit_sel   = sel_q;
  assign busy        = busy_q;
  assign load        = load_q;
  assign set_hours   = sh_q;
  assign set_minutes = sm_q;
  assign set_seconds = ss_q;

endmodule
